// File: rtl/iter_div_pkg.sv
// iter_div_pkg: state codes, handshake levels and helpers for the iterative divider.
package iter_div_pkg;

    typedef enum logic [1:0] {
        DIV_FREE    = 2'b00,
        DIV_BY_ZERO = 2'b01,
        DIV_ON      = 2'b10,
        DIV_END     = 2'b11
    } div_state_e;

    localparam logic        DIV_START            = 1'b1;
    localparam logic        DIV_STOP             = 1'b0;
    localparam logic        DIV_RESULT_READY     = 1'b1;
    localparam logic        DIV_RESULT_NOT_READY = 1'b0;
    localparam logic [31:0] ZERO_WORD            = 32'h0000_0000;

    function automatic logic [31:0] magnitude(input logic neg, input logic [31:0] v);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/iter_div.sv
// iter_div: 32-bit radix-2 restoring divider, one quotient bit per cycle.
// result_o = {remainder, quotient}; ready_o held until the requester drops start_i.
module iter_div
    import iter_div_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    div_state_e  state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [64:0] work_q, work_d;
    logic [31:0] divisor_q, divisor_d;
    logic        signed_q, signed_d;
    logic        sign1_q, sign1_d;
    logic        sign2_q, sign2_d;
    logic [63:0] result_q, result_d;
    logic        ready_q, ready_d;
    logic [32:0] trial;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        work_d    = work_q;
        divisor_d = divisor_q;
        signed_d  = signed_q;
        sign1_d   = sign1_q;
        sign2_d   = sign2_q;
        result_d  = result_q;
        ready_d   = ready_q;
        trial     = {1'b0, work_q[63:32]} - {1'b0, divisor_q};
        quot_fix  = magnitude(signed_q && (sign1_q ^ sign2_q), work_q[31:0]);
        rem_fix   = magnitude(signed_q && sign1_q, work_q[64:33]);
        case (state_q)
            DIV_FREE: begin
                result_d = '0;
                ready_d  = DIV_RESULT_NOT_READY;
                if (start_i == DIV_START && !annul_i) begin
                    if (opdata2_i == ZERO_WORD) begin
                        state_d = DIV_BY_ZERO;
                    end else begin
                        signed_d  = signed_div_i;
                        sign1_d   = opdata1_i[31];
                        sign2_d   = opdata2_i[31];
                        divisor_d = magnitude(signed_div_i && opdata2_i[31], opdata2_i);
                        work_d    = {ZERO_WORD, magnitude(signed_div_i && opdata1_i[31], opdata1_i), 1'b0};
                        cnt_d     = '0;
                        state_d   = DIV_ON;
                    end
                end
            end
            DIV_BY_ZERO: begin
                result_d = '0;
                ready_d  = DIV_RESULT_READY;
                state_d  = DIV_END;
            end
            DIV_ON: begin
                if (cnt_q == 6'd32) begin
                    result_d = {rem_fix, quot_fix};
                    ready_d  = DIV_RESULT_READY;
                    state_d  = DIV_END;
                end else begin
                    // Negative trial means the divisor did not fit: shift in a 0 and keep the partial remainder.
                    work_d = trial[32] ? {work_q[63:0], 1'b0} : {trial[31:0], work_q[31:0], 1'b1};
                    cnt_d  = cnt_q + 6'd1;
                end
            end
            default: begin
                if (start_i == DIV_STOP) begin
                    result_d = '0;
                    ready_d  = DIV_RESULT_NOT_READY;
                    state_d  = DIV_FREE;
                end
            end
        endcase
        if (annul_i && state_q != DIV_FREE) begin
            result_d = '0;
            ready_d  = DIV_RESULT_NOT_READY;
            state_d  = DIV_FREE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= DIV_FREE;
            cnt_q     <= '0;
            work_q    <= '0;
            divisor_q <= '0;
            signed_q  <= 1'b0;
            sign1_q   <= 1'b0;
            sign2_q   <= 1'b0;
            result_q  <= '0;
            ready_q   <= DIV_RESULT_NOT_READY;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            work_q    <= work_d;
            divisor_q <= divisor_d;
            signed_q  <= signed_d;
            sign1_q   <= sign1_d;
            sign2_q   <= sign2_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule
